systolic_feed_controller: RTL and testbench
===========================================

Name: systolic_feed_controller

Overview:
- Sequences one matrix-multiply tile through a ROWS x COLS processing-element array. Issues diagonally skewed input_start enables to the row (x) and column (w) edges.
- Drives the operand-buffer step index, holds off on PE stall, waits out the MAC pipeline drain, then pulses done.
- Sits between the tile-level command interface and the array edge / operand buffers.

Parameters:
- ROWS, 4, number of array rows (x edge inputs)
- COLS, 4, number of array columns (w edge inputs)
- STEP_W, 16, width of cfg_k and the step counter
- DRAIN_CYCLES, 8, cycles to wait after the last feed step for in-flight MACs to complete (>=1)

Ports:
- clk  in  1  clock
- n_rst  in  1  reset, asynchronous, active-low
- start  in  1  launch pulse; sampled only in IDLE
- abort  in  1  synchronous abort; return to IDLE, no done
- cfg_k  in  STEP_W  inner-product length; latched on accepted start
- pe_stall  in  1  OR of edge-PE stall outputs; freezes feeding
- row_start  out  ROWS  per-row input_start to the x edge
- col_start  out  COLS  per-column input_start to the w edge
- feed_step  out  STEP_W  global step s; buffer for row/col i reads element s-i
- feed_valid  out  1  high on cycles where s advances (any row/col enable set)
- busy  out  1  high in FEED, DRAIN, DONE
- done  out  1  one-cycle pulse at tile completion

Behaviour:
- Reset: state IDLE. All outputs 0: row_start, col_start, feed_step, feed_valid, busy, done. Latched k = 0, drain counter = 0.
- States are IDLE, FEED, DRAIN, DONE.
- IDLE:
  - start=1 and cfg_k!=0: latch K=cfg_k, s=0, go to FEED next cycle.
  - start=1 and cfg_k==0: go directly to DONE (no enables issued).
- FEED:
  - LAST = K + max(ROWS,COLS) - 2.
  - row_start[r] = !pe_stall && (r <= s) && (s < r+K). col_start[c] uses the same rule with c.
  - feed_valid = !pe_stall. feed_step = s (registered, valid in the same cycle as the enables).
  - If !pe_stall: s increments. If s==LAST, go to DRAIN with drain counter = DRAIN_CYCLES-1.
  - If pe_stall: s holds and all enables are 0.
  - Step arithmetic is unsigned STEP_W with no wrap. The K + max(ROWS,COLS) - 2 < 2^STEP_W range is a config precondition; the verification bench flags violations.
- DRAIN:
  - All enables are 0.
  - The drain counter decrements each cycle pe_stall=0 and holds while pe_stall=1.
  - At 0 with pe_stall=0: go to DONE.
- DONE: done=1 for exactly one cycle, busy=1, then IDLE.
- start outside IDLE is ignored (not queued). busy falls the cycle after done.
- abort (any non-IDLE state): next cycle IDLE, all outputs 0, done not asserted. abort has priority over start in the same cycle. abort in IDLE has no effect.
- Latency: start -> first row_start[0] is 1 cycle. With no stalls, start -> done is 1 + (LAST+1) + DRAIN_CYCLES cycles.
- Async reset mid-tile: immediate return to reset values; no done.

Optional Feature:
- Macro SYSTOLIC_FEED_PERF_EN.
- When defined, adds outputs:
  - perf_stall_cycles (32): FEED/DRAIN cycles with pe_stall=1.
  - perf_tile_cycles (32): cycles from start acceptance to done.
- Both counters clear on accepted start, saturate at all-ones, and hold after done until the next start.
- When undefined, the ports and logic are absent; behaviour is otherwise identical.

Test Plan:
- ROWS=COLS=4, cfg_k=3, no stall, start pulse:
  - row_start[0] high at s=0..2; row_start[3] high at s=3..5; LAST=5.
  - done exactly 1+6+8=15 cycles after start.
- cfg_k=4, pe_stall held high for 3 cycles at s=2:
  - feed_step holds at 2, enables 0 during the stall, resumes at 2.
  - done delayed by exactly 3 cycles versus the no-stall run.
- cfg_k=0 start: done pulse on the 2nd cycle, no row/col enable ever set, busy high 1 cycle.
- start pulsed again during FEED and during DRAIN: ignored; exactly one done; K unchanged even if cfg_k changes.
- abort during FEED at s=3: next cycle IDLE, all outputs 0, no done. A fresh start then runs a full tile normally.
- n_rst asserted asynchronously mid-DRAIN: outputs 0 immediately. With SYSTOLIC_FEED_PERF_EN: after a run with 3 stall cycles, perf_stall_cycles=3 and perf_tile_cycles matches the measured start-to-done count.

Source files
------------

// File: rtl/systolic_feed_controller.sv
// Feed sequencer for one matrix-multiply tile on a ROWS x COLS systolic array.
// Define SYSTOLIC_FEED_PERF_EN to add the stall and tile-length performance counters.
module systolic_feed_controller #(
    parameter int unsigned ROWS         = 4,
    parameter int unsigned COLS         = 4,
    parameter int unsigned STEP_W       = 16,
    parameter int unsigned DRAIN_CYCLES = 8
) (
    input  logic              clk,
    input  logic              n_rst,
    input  logic              start,
    input  logic              abort,
    input  logic [STEP_W-1:0] cfg_k,
    input  logic              pe_stall,
    output logic [ROWS-1:0]   row_start,
    output logic [COLS-1:0]   col_start,
    output logic [STEP_W-1:0] feed_step,
    output logic              feed_valid,
    output logic              busy,
    output logic              done
`ifdef SYSTOLIC_FEED_PERF_EN
    ,
    output logic [31:0]       perf_stall_cycles,
    output logic [31:0]       perf_tile_cycles
`endif
);

    localparam int unsigned MAXD = (ROWS > COLS) ? ROWS : COLS;
    localparam int unsigned XW   = STEP_W + 1;
    localparam int unsigned DW   = (DRAIN_CYCLES > 1) ? $clog2(DRAIN_CYCLES) : 1;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_FEED  = 2'd1,
        ST_DRAIN = 2'd2,
        ST_DONE  = 2'd3
    } state_e;

    state_e            state_q, state_d;
    logic [STEP_W-1:0] s_q, s_d;
    logic [STEP_W-1:0] k_q, k_d;
    logic [DW-1:0]     drain_q, drain_d;
    logic              busy_q, busy_d;
    logic              done_q, done_d;

    logic [XW-1:0]     s_x, k_x, last_x;
    logic              feed_en;

    // Extended by one bit so the skew window compare cannot overflow.
    assign s_x    = {1'b0, s_q};
    assign k_x    = {1'b0, k_q};
    assign last_x = k_x + XW'(MAXD) - XW'(2);

    // State and datapath registers
    always_ff @(posedge clk or negedge n_rst) begin
        if (!n_rst) begin
            state_q <= ST_IDLE;
            s_q     <= '0;
            k_q     <= '0;
            drain_q <= '0;
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            s_q     <= s_d;
            k_q     <= k_d;
            drain_q <= drain_d;
            busy_q  <= busy_d;
            done_q  <= done_d;
        end
    end

    // Next-state and step/drain sequencing
    always_comb begin
        state_d = state_q;
        s_d     = s_q;
        k_d     = k_q;
        drain_d = drain_q;
        if (abort && (state_q != ST_IDLE)) begin
            state_d = ST_IDLE;
            s_d     = '0;
            drain_d = '0;
        end else begin
            case (state_q)
                ST_IDLE: begin
                    if (start) begin
                        s_d = '0;
                        if (cfg_k != '0) begin
                            k_d     = cfg_k;
                            state_d = ST_FEED;
                        end else begin
                            state_d = ST_DONE;
                        end
                    end
                end
                ST_FEED: begin
                    if (!pe_stall) begin
                        if (s_x == last_x) begin
                            s_d     = '0;
                            drain_d = DW'(DRAIN_CYCLES - 1);
                            state_d = ST_DRAIN;
                        end else begin
                            s_d = s_q + STEP_W'(1);
                        end
                    end
                end
                ST_DRAIN: begin
                    if (!pe_stall) begin
                        if (drain_q == '0) begin
                            state_d = ST_DONE;
                        end else begin
                            drain_d = drain_q - DW'(1);
                        end
                    end
                end
                ST_DONE: begin
                    state_d = ST_IDLE;
                end
                default: begin
                    state_d = ST_IDLE;
                end
            endcase
        end
    end

    // Edge enables follow the diagonal skew: lane i is live for steps i .. i+K-1.
    always_comb begin
        row_start = '0;
        col_start = '0;
        feed_en   = (state_q == ST_FEED) && !pe_stall;
        for (int r = 0; r < ROWS; r++) begin
            row_start[r] = feed_en && (XW'(r) <= s_x) && (s_x < (XW'(r) + k_x));
        end
        for (int c = 0; c < COLS; c++) begin
            col_start[c] = feed_en && (XW'(c) <= s_x) && (s_x < (XW'(c) + k_x));
        end
        busy_d = (state_d != ST_IDLE);
        done_d = (state_d == ST_DONE);
    end

    assign feed_valid = feed_en;
    assign feed_step  = s_q;
    assign busy       = busy_q;
    assign done       = done_q;

`ifdef SYSTOLIC_FEED_PERF_EN
    logic [31:0] pstall_q;
    logic [31:0] ptile_q;

    // Saturating counters, cleared on an accepted start and frozen once idle.
    always_ff @(posedge clk or negedge n_rst) begin
        if (!n_rst) begin
            pstall_q <= '0;
            ptile_q  <= '0;
        end else if ((state_q == ST_IDLE) && start) begin
            pstall_q <= '0;
            ptile_q  <= '0;
        end else begin
            if ((state_q != ST_IDLE) && (ptile_q != '1)) begin
                ptile_q <= ptile_q + 32'd1;
            end
            if (((state_q == ST_FEED) || (state_q == ST_DRAIN)) && pe_stall && (pstall_q != '1)) begin
                pstall_q <= pstall_q + 32'd1;
            end
        end
    end

    assign perf_stall_cycles = pstall_q;
    assign perf_tile_cycles  = ptile_q;
`endif

endmodule

// File: tb/tb_systolic_feed_controller.sv
// Randomised bench for systolic_feed_controller against a slot-count tile model.
module tb_systolic_feed_controller;

    localparam int unsigned ROWS   = 4;
    localparam int unsigned COLS   = 4;
    localparam int unsigned STEP_W = 16;
    localparam int unsigned DRAIN  = 8;
    localparam int unsigned MAXD   = 4;

    logic              clk;
    logic              n_rst;
    logic              start;
    logic              abort;
    logic [STEP_W-1:0] cfg_k;
    logic              pe_stall;
    logic [ROWS-1:0]   row_start;
    logic [COLS-1:0]   col_start;
    logic [STEP_W-1:0] feed_step;
    logic              feed_valid;
    logic              busy;
    logic              done;
`ifdef SYSTOLIC_FEED_PERF_EN
    logic [31:0]       perf_stall_cycles;
    logic [31:0]       perf_tile_cycles;
`endif

    systolic_feed_controller #(
        .ROWS(ROWS), .COLS(COLS), .STEP_W(STEP_W), .DRAIN_CYCLES(DRAIN)
    ) dut (
        .clk(clk), .n_rst(n_rst), .start(start), .abort(abort), .cfg_k(cfg_k),
        .pe_stall(pe_stall), .row_start(row_start), .col_start(col_start),
        .feed_step(feed_step), .feed_valid(feed_valid), .busy(busy), .done(done)
`ifdef SYSTOLIC_FEED_PERF_EN
        , .perf_stall_cycles(perf_stall_cycles), .perf_tile_cycles(perf_tile_cycles)
`endif
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int n_cmp = 0;
    int n_err = 0;

    // Tile model: a tile is a row of slots; slots advance only on unstalled cycles.
    bit          m_active;
    int          m_slot, m_k, m_nfeed, m_total;
    int unsigned m_pstall, m_ptile;

    int cyc, last_start_cyc, last_done_cyc, done_count, busy_cycles, en_cycles;

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%0h expected 0x%0h (cycle %0d)", tag, got, exp, cyc);
        end
    endtask

    task automatic check_outputs();
        bit in_feed;
        logic [ROWS-1:0] er;
        logic [COLS-1:0] ec;
        in_feed = m_active && (m_slot < m_nfeed);
        er = '0;
        ec = '0;
        for (int r = 0; r < int'(ROWS); r++)
            er[r] = in_feed && !pe_stall && (r <= m_slot) && (m_slot < r + m_k);
        for (int c = 0; c < int'(COLS); c++)
            ec[c] = in_feed && !pe_stall && (c <= m_slot) && (m_slot < c + m_k);
        check_eq("busy", 32'(busy), 32'(m_active));
        check_eq("done", 32'(done), 32'(m_active && (m_slot == m_total)));
        check_eq("feed_valid", 32'(feed_valid), 32'(in_feed && !pe_stall));
        check_eq("row_start", 32'(row_start), 32'(er));
        check_eq("col_start", 32'(col_start), 32'(ec));
        if (in_feed) check_eq("feed_step", 32'(feed_step), 32'(m_slot));
`ifdef SYSTOLIC_FEED_PERF_EN
        check_eq("perf_stall", perf_stall_cycles, m_pstall);
        check_eq("perf_tile", perf_tile_cycles, m_ptile);
`endif
        if (done === 1'b1) begin
            done_count++;
            last_done_cyc = cyc;
        end
        if (busy === 1'b1) busy_cycles++;
        if ((row_start != '0) || (col_start != '0)) en_cycles++;
    endtask

    task automatic advance();
        if (!m_active) begin
            if (start) begin
                m_active       = 1'b1;
                m_slot         = 0;
                m_k            = int'(cfg_k);
                m_nfeed        = (m_k == 0) ? 0 : m_k + int'(MAXD) - 1;
                m_total        = m_nfeed + ((m_k == 0) ? 0 : int'(DRAIN));
                m_pstall       = 0;
                m_ptile        = 0;
                last_start_cyc = cyc;
            end
        end else begin
            m_ptile++;
            if (pe_stall && (m_slot < m_total)) m_pstall++;
            if (abort) m_active = 1'b0;
            else if (m_slot == m_total) m_active = 1'b0;
            else if (!pe_stall) m_slot++;
        end
    endtask

    // Called just after a rising edge; inputs are already set by the caller.
    task automatic tick();
        #2;
        check_outputs();
        @(posedge clk);
        advance();
        cyc++;
        #1;
    endtask

    task automatic idle_inputs();
        start = 1'b0; abort = 1'b0; pe_stall = 1'b0;
    endtask

    task automatic launch(input int k);
        start = 1'b1; abort = 1'b0; pe_stall = 1'b0; cfg_k = STEP_W'(k);
        tick();
        start = 1'b0;
    endtask

    task automatic run_until_done(input int budget, input bit rnd_stall);
        int dc0;
        dc0 = done_count;
        for (int i = 0; i < budget && done_count == dc0; i++) begin
            start = 1'b0; abort = 1'b0;
            pe_stall = rnd_stall ? ($urandom_range(3) == 0) : 1'b0;
            tick();
        end
        check_eq("done_seen", 32'(done_count - dc0), 32'd1);
    endtask

    task automatic check_all_zero(input string tag);
        check_eq({tag, "_row"}, 32'(row_start), 32'd0);
        check_eq({tag, "_col"}, 32'(col_start), 32'd0);
        check_eq({tag, "_step"}, 32'(feed_step), 32'd0);
        check_eq({tag, "_valid"}, 32'(feed_valid), 32'd0);
        check_eq({tag, "_busy"}, 32'(busy), 32'd0);
        check_eq({tag, "_done"}, 32'(done), 32'd0);
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end

    initial begin
        int dc0, bc0, ec0, k;
        n_rst = 1'b0; cfg_k = '0; idle_inputs();
        m_active = 1'b0; m_slot = 0; m_k = 0; m_nfeed = 0; m_total = 0;
        m_pstall = 0; m_ptile = 0;
        cyc = 0; last_start_cyc = 0; last_done_cyc = 0; done_count = 0;
        busy_cycles = 0; en_cycles = 0;
        repeat (2) @(posedge clk);
        #1;
        check_all_zero("reset");
        n_rst = 1'b1;
        repeat (3) tick();

        // K=3, no stall: LAST=5, done 15 cycles after start
        launch(3);
        run_until_done(100, 1'b0);
        check_eq("lat_k3", 32'(last_done_cyc - last_start_cyc), 32'd15);
        tick();

        // K=4 with a 3-cycle stall at s=2: latency 16+3
        launch(4);
        repeat (2) tick();
        pe_stall = 1'b1;
        repeat (3) tick();
        pe_stall = 1'b0;
        #2;
        check_eq("stall_resume_step", 32'(feed_step), 32'd2);
        #1;
        @(posedge clk);
        #1;
        cyc++;
        m_slot++;
        m_ptile++;
        run_until_done(100, 1'b0);
        check_eq("lat_k4_stall", 32'(last_done_cyc - last_start_cyc), 32'd19);
`ifdef SYSTOLIC_FEED_PERF_EN
        #2;
        check_eq("perf_stall_3", perf_stall_cycles, 32'd3);
        check_eq("perf_tile_meas", perf_tile_cycles, 32'(last_done_cyc - last_start_cyc));
        @(posedge clk);
        cyc++;
        m_active = 1'b0;
        #1;
`endif
        tick();

        // K=0: done on the second cycle, busy for one cycle, no enables
        bc0 = busy_cycles; ec0 = en_cycles;
        launch(0);
        run_until_done(10, 1'b0);
        check_eq("lat_k0", 32'(last_done_cyc - last_start_cyc), 32'd1);
        repeat (3) tick();
        check_eq("k0_busy_cycles", 32'(busy_cycles - bc0), 32'd1);
        check_eq("k0_enables", 32'(en_cycles - ec0), 32'd0);

        // Extra starts during FEED and DRAIN are ignored and cannot change K
        dc0 = done_count;
        launch(3);
        repeat (2) tick();
        start = 1'b1; cfg_k = STEP_W'(9);
        tick();
        start = 1'b0;
        for (int i = 0; i < 20 && (m_slot < m_nfeed + 2); i++) tick();
        start = 1'b1; cfg_k = STEP_W'(2);
        tick();
        start = 1'b0;
        run_until_done(100, 1'b0);
        check_eq("lat_restart_ign", 32'(last_done_cyc - last_start_cyc), 32'd15);
        repeat (20) tick();
        check_eq("one_done", 32'(done_count - dc0), 32'd1);

        // Abort at s=3: idle next cycle, no done, then a clean tile
        dc0 = done_count;
        launch(5);
        repeat (3) tick();
        abort = 1'b1;
        tick();
        abort = 1'b0;
        #2;
        check_all_zero("abort");
        #1;
        @(posedge clk);
        cyc++;
        #1;
        repeat (20) tick();
        check_eq("abort_no_done", 32'(done_count - dc0), 32'd0);
        launch(3);
        run_until_done(100, 1'b0);
        check_eq("lat_after_abort", 32'(last_done_cyc - last_start_cyc), 32'd15);
        tick();

        // Asynchronous reset in the middle of DRAIN
        dc0 = done_count;
        launch(2);
        for (int i = 0; i < 50 && !(m_active && m_slot >= m_nfeed + 2); i++) tick();
        check_eq("reached_drain", 32'(m_active && m_slot >= m_nfeed + 2), 32'd1);
        n_rst = 1'b0;
        #1;
        check_all_zero("async_rst");
`ifdef SYSTOLIC_FEED_PERF_EN
        check_eq("async_rst_perf", perf_tile_cycles, 32'd0);
`endif
        m_active = 1'b0; m_pstall = 0; m_ptile = 0;
        #1;
        n_rst = 1'b1;
        repeat (20) tick();
        check_eq("rst_no_done", 32'(done_count - dc0), 32'd0);

        // Random tiles with random stalls, spurious starts and rare aborts
        for (int t = 0; t < 25; t++) begin
            k = int'($urandom_range(9));
            launch(k);
            for (int i = 0; i < 300 && m_active; i++) begin
                pe_stall = ($urandom_range(3) == 0);
                start    = ($urandom_range(7) == 0);
                cfg_k    = STEP_W'($urandom);
                abort    = ($urandom_range(40) == 0);
                tick();
            end
            check_eq("rand_finished", 32'(m_active), 32'd0);
            idle_inputs();
            repeat ($urandom_range(3)) tick();
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
